// File: rtl/mem_responder_if.sv
// Word request/response bundle between the CPU control path and memory.
// The CPU holds mem_en high until it sees mem_ready (4-phase handshake).
interface mem_responder_if;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: on-chip RAM, one memory-mapped I/O word,
// programmable wait states and a program-load port usable while idle.
module mem_responder #(
    parameter int          DEPTH   = 256,
    parameter int          LATENCY = 2,
    parameter logic [15:0] IO_ADDR = 16'hFFFF
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus,
    input  logic [15:0]     sw,
    output logic [15:0]     hex_out,
    input  logic            init_we,
    input  logic [15:0]     init_addr,
    input  logic [15:0]     init_data,
    output logic            busy
);

    localparam int         AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] LAT = 4'(LATENCY);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic [15:0] hex_q, hex_d;

    logic [15:0]   ram_q [DEPTH];
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [15:0]   ram_wdata;

    function automatic logic in_range(input logic [15:0] a);
        return {16'h0, a} < 32'(DEPTH);
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        hex_d     = hex_q;
        ram_we    = 1'b0;
        ram_waddr = init_addr[AW-1:0];
        ram_wdata = init_data;
        case (state_q)
            IDLE: begin
                // Program load takes priority; the request simply waits.
                if (init_we) begin
                    ram_we = in_range(init_addr);
                end else if (bus.mem_en) begin
                    we_d    = bus.mem_we;
                    addr_d  = bus.mem_addr;
                    wdata_d = bus.mem_wdata;
                    cnt_d   = LAT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = RESP;
                    if (we_q) begin
                        rdata_d = wdata_q;
                        if (addr_q == IO_ADDR) begin
                            hex_d = wdata_q;
                        end else if (in_range(addr_q)) begin
                            ram_we    = 1'b1;
                            ram_waddr = addr_q[AW-1:0];
                            ram_wdata = wdata_q;
                        end
                    end else if (addr_q == IO_ADDR) begin
                        rdata_d = sw;
                    end else if (in_range(addr_q)) begin
                        rdata_d = ram_q[addr_q[AW-1:0]];
                    end else begin
                        rdata_d = 16'h0000;
                    end
                end
            end
            RESP: begin
                if (!bus.mem_en) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 16'h0;
            wdata_q <= 16'h0;
            rdata_q <= 16'h0;
            hex_q   <= 16'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            hex_q   <= hex_d;
        end
    end

    // RAM keeps its contents across reset; writes are blocked while it is held.
    always_ff @(posedge clk) begin
        if (ram_we && !reset) ram_q[ram_waddr] <= ram_wdata;
    end

    assign bus.mem_ready = (state_q == RESP);
    assign bus.mem_rdata = rdata_q;
    assign hex_out       = hex_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a LATENCY=2 instance for the
// main scenarios plus a LATENCY=0 instance for the short-wait case.
module tb_mem_responder;

    logic        clk;
    logic        reset;
    logic [15:0] sw;
    logic        init_we;
    logic [15:0] init_addr;
    logic [15:0] init_data;
    logic [15:0] hex0, hex1;
    logic        busy0, busy1;

    int n_chk  = 0;
    int n_fail = 0;

    mem_responder_if bus ();
    mem_responder_if bus1 ();

    mem_responder #(.DEPTH(256), .LATENCY(2), .IO_ADDR(16'hFFFF)) u0 (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .sw        (sw),
        .hex_out   (hex0),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data),
        .busy      (busy0)
    );

    mem_responder #(.DEPTH(256), .LATENCY(0), .IO_ADDR(16'hFFFF)) u1 (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus1),
        .sw        (sw),
        .hex_out   (hex1),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data),
        .busy      (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [15:0] a, input logic [15:0] d);
        init_we   = 1'b1;
        init_addr = a;
        init_data = d;
        @(negedge clk);
        init_we   = 1'b0;
    endtask

    // Acceptance edge, optional mid-WAIT disturbance, then count edges to ready.
    task automatic wait_done(input bit drop, input bit chg,
                             input logic [15:0] new_addr, input bit poke,
                             output int edges);
        @(posedge clk);
        #1;
        if (drop) bus.mem_en = 1'b0;
        if (chg)  bus.mem_addr = new_addr;
        if (poke) begin
            init_we   = 1'b1;
            init_addr = 16'd20;
            init_data = 16'h9999;
        end
        edges = 0;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            init_we = 1'b0;
        end while (!bus.mem_ready && edges < 40);
    endtask

    task automatic req(input logic we, input logic [15:0] a,
                       input logic [15:0] d, output int edges);
        bus.mem_we    = we;
        bus.mem_addr  = a;
        bus.mem_wdata = d;
        bus.mem_en    = 1'b1;
        wait_done(1'b0, 1'b0, 16'h0, 1'b0, edges);
    endtask

    task automatic drop();
        bus.mem_en = 1'b0;
        @(negedge clk);
    endtask

    int e;

    initial begin
        reset = 1'b1;
        sw = 16'h0; init_we = 1'b0; init_addr = 16'h0; init_data = 16'h0;
        bus.mem_en = 1'b0; bus.mem_we = 1'b0;
        bus.mem_addr = 16'h0; bus.mem_wdata = 16'h0;
        bus1.mem_en = 1'b0; bus1.mem_we = 1'b0;
        bus1.mem_addr = 16'h0; bus1.mem_wdata = 16'h0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus.mem_ready), 32'h0);
        check("rst_rdata", 32'(bus.mem_rdata), 32'h0);
        check("rst_hex",   32'(hex0), 32'h0);
        check("rst_busy",  32'(busy0), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Program load then read with LATENCY=2
        load(16'd5, 16'h1234);
        req(1'b0, 16'd5, 16'h0, e);
        check("ld_edges", 32'(e), 32'd3);
        check("ld_rdata", 32'(bus.mem_rdata), 32'h1234);
        @(negedge clk);
        check("ld_hold_rdy", 32'(bus.mem_ready), 32'h1);
        check("ld_hold_dat", 32'(bus.mem_rdata), 32'h1234);
        drop();
        check("ld_rdy_low", 32'(bus.mem_ready), 32'h0);
        check("ld_busy_low", 32'(busy0), 32'h0);

        // Write then read back
        req(1'b1, 16'h00FF, 16'hBEEF, e);
        check("wr_edges", 32'(e), 32'd3);
        check("wr_echo", 32'(bus.mem_rdata), 32'hBEEF);
        drop();
        req(1'b0, 16'h00FF, 16'h0, e);
        check("rb_data", 32'(bus.mem_rdata), 32'hBEEF);
        drop();

        // I/O word
        sw = 16'h00A5;
        req(1'b0, 16'hFFFF, 16'h0, e);
        check("io_rd", 32'(bus.mem_rdata), 32'h00A5);
        drop();
        req(1'b1, 16'hFFFF, 16'h0042, e);
        check("io_hex", 32'(hex0), 32'h0042);
        check("io_echo", 32'(bus.mem_rdata), 32'h0042);
        drop();
        req(1'b0, 16'h00FF, 16'h0, e);
        check("io_ram_keep", 32'(bus.mem_rdata), 32'hBEEF);
        drop();

        // Out of range
        load(16'd0, 16'hABCD);
        req(1'b1, 16'h0100, 16'h7777, e);
        check("oor_echo", 32'(bus.mem_rdata), 32'h7777);
        drop();
        req(1'b0, 16'h0100, 16'h0, e);
        check("oor_rd", 32'(bus.mem_rdata), 32'h0);
        drop();
        req(1'b0, 16'h0000, 16'h0, e);
        check("oor_ram0", 32'(bus.mem_rdata), 32'hABCD);
        drop();

        // init_we beats mem_en; request waits until init_we drops
        init_we = 1'b1; init_addr = 16'd10; init_data = 16'h2222;
        bus.mem_we = 1'b0; bus.mem_addr = 16'd10; bus.mem_en = 1'b1;
        @(negedge clk);
        check("prio_busy1", 32'(busy0), 32'h0);
        @(negedge clk);
        check("prio_busy2", 32'(busy0), 32'h0);
        init_we = 1'b0;
        wait_done(1'b0, 1'b0, 16'h0, 1'b0, e);
        check("prio_edges", 32'(e), 32'd3);
        check("prio_data", 32'(bus.mem_rdata), 32'h2222);
        drop();

        // Address change after acceptance is ignored
        bus.mem_we = 1'b0; bus.mem_addr = 16'd5; bus.mem_en = 1'b1;
        wait_done(1'b0, 1'b1, 16'd10, 1'b0, e);
        check("chg_addr", 32'(bus.mem_rdata), 32'h1234);
        drop();

        // init_we outside IDLE is ignored
        load(16'd20, 16'h3333);
        bus.mem_we = 1'b0; bus.mem_addr = 16'd5; bus.mem_en = 1'b1;
        wait_done(1'b0, 1'b0, 16'h0, 1'b1, e);
        drop();
        req(1'b0, 16'd20, 16'h0, e);
        check("init_busy_ign", 32'(bus.mem_rdata), 32'h3333);
        drop();

        // mem_en dropped in WAIT: one-cycle ready pulse
        bus.mem_we = 1'b0; bus.mem_addr = 16'h00FF; bus.mem_en = 1'b1;
        wait_done(1'b1, 1'b0, 16'h0, 1'b0, e);
        check("pulse_edges", 32'(e), 32'd3);
        check("pulse_hi", 32'(bus.mem_ready), 32'h1);
        check("pulse_data", 32'(bus.mem_rdata), 32'hBEEF);
        @(negedge clk);
        check("pulse_lo", 32'(bus.mem_ready), 32'h0);
        check("pulse_busy", 32'(busy0), 32'h0);

        // Reset in the middle of a write
        load(16'd3, 16'h1111);
        bus.mem_we = 1'b1; bus.mem_addr = 16'd3;
        bus.mem_wdata = 16'h5555; bus.mem_en = 1'b1;
        @(posedge clk);
        #1;
        check("mid_busy", 32'(busy0), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rdy", 32'(bus.mem_ready), 32'h0);
        check("mid_rdata", 32'(bus.mem_rdata), 32'h0);
        check("mid_hex", 32'(hex0), 32'h0);
        check("mid_busy0", 32'(busy0), 32'h0);
        @(negedge clk);
        bus.mem_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        req(1'b0, 16'd3, 16'h0, e);
        check("mid_ram3", 32'(bus.mem_rdata), 32'h1111);
        drop();

        // LATENCY=0 instance
        bus1.mem_we = 1'b1; bus1.mem_addr = 16'd7;
        bus1.mem_wdata = 16'h0F0F; bus1.mem_en = 1'b1;
        @(posedge clk);
        e = 0;
        do begin
            @(posedge clk);
            e++;
            @(negedge clk);
        end while (!bus1.mem_ready && e < 40);
        check("l0_wr_edges", 32'(e), 32'd1);
        check("l0_echo", 32'(bus1.mem_rdata), 32'h0F0F);
        bus1.mem_en = 1'b0;
        @(negedge clk);
        check("l0_busy", 32'(busy1), 32'h0);
        bus1.mem_we = 1'b0; bus1.mem_en = 1'b1;
        @(posedge clk);
        e = 0;
        do begin
            @(posedge clk);
            e++;
            @(negedge clk);
        end while (!bus1.mem_ready && e < 40);
        check("l0_rd_edges", 32'(e), 32'd1);
        check("l0_rd_data", 32'(bus1.mem_rdata), 32'h0F0F);
        bus1.mem_en = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
